// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for a picorv32-native memory bus, with a
// mandatory IDLE turnaround between transactions and a no-ack watchdog.
module mem_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m0_addr,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_wdata,
  input  logic [31:0] m1_addr,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_wdata,
  output logic [31:0] s_addr,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        timeout_err
);

  localparam int unsigned WDOG_W = 16;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t            state;
  logic              last_grant;
  logic [WDOG_W-1:0] wdog;

  logic        granted;
  logic        cur_valid;
  logic        timeout_hit;
  logic        txn_end;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;

  assign granted     = (state == GRANT0) || (state == GRANT1);
  assign cur_valid   = (state == GRANT1) ? m1_valid : m0_valid;
  // Watchdog fires on the TIMEOUT-th granted cycle without an acknowledge.
  assign timeout_hit = granted && cur_valid && !s_ready && (wdog == WDOG_LAST);
  assign txn_end     = s_ready || timeout_hit || !cur_valid;
  assign rsp_ready   = s_ready || timeout_hit;
  assign rsp_rdata   = timeout_hit ? ERR_DATA : s_rdata;

  // Request mux toward the shared bus; all zero while idle.
  always_comb begin
    s_valid = 1'b0;
    s_instr = 1'b0;
    s_wstrb = 4'b0000;
    s_wdata = 32'h0;
    s_addr  = 32'h0;
    if (state == GRANT0) begin
      s_valid = m0_valid;
      s_instr = m0_instr;
      s_wstrb = m0_wstrb;
      s_wdata = m0_wdata;
      s_addr  = m0_addr;
    end else if (state == GRANT1) begin
      s_valid = m1_valid;
      s_instr = m1_instr;
      s_wstrb = m1_wstrb;
      s_wdata = m1_wdata;
      s_addr  = m1_addr;
    end
  end

  always_comb begin
    m0_ready = 1'b0;
    m0_rdata = 32'h0;
    m1_ready = 1'b0;
    m1_rdata = 32'h0;
    if (state == GRANT0) begin
      m0_ready = rsp_ready;
      m0_rdata = rsp_rdata;
    end else if (state == GRANT1) begin
      m1_ready = rsp_ready;
      m1_rdata = rsp_rdata;
    end
  end

  // Arbitration state, round-robin pointer, watchdog and sticky error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_valid && (!m1_valid || last_grant)) begin
            state      <= GRANT0;
            last_grant <= 1'b0;
            wdog       <= '0;
          end else if (m1_valid) begin
            state      <= GRANT1;
            last_grant <= 1'b1;
            wdog       <= '0;
          end
        end
        GRANT0, GRANT1: begin
          if (timeout_hit) timeout_err <= 1'b1;
          if (txn_end) state <= IDLE;
          else         wdog  <= wdog + WDOG_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a short watchdog (TIMEOUT = 8).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_wdata, m0_addr, m1_wdata, m1_addr;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_instr, s_ready, timeout_err;
  logic [3:0]  s_wstrb;
  logic [31:0] s_wdata, s_addr, s_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_wstrb(m0_wstrb),
    .m0_wdata(m0_wdata), .m0_addr(m0_addr), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_wstrb(m1_wstrb),
    .m1_wdata(m1_wdata), .m1_addr(m1_addr), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_wstrb(s_wstrb), .s_wdata(s_wdata),
    .s_addr(s_addr), .s_ready(s_ready), .s_rdata(s_rdata), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #12;
    resetn = 1'b1;
    #1;
  endtask

  initial begin
    resetn   = 1'b0;
    m0_valid = 1'b0; m0_instr = 1'b0; m0_wstrb = 4'h0; m0_wdata = 32'h0; m0_addr = 32'h0;
    m1_valid = 1'b0; m1_instr = 1'b0; m1_wstrb = 4'h0; m1_wdata = 32'h0; m1_addr = 32'h0;
    s_ready  = 1'b1; s_rdata = 32'h55AA55AA;
    #7;
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_m0_ready", 32'(m0_ready), 32'd0);
    chk("rst_m1_ready", 32'(m1_ready), 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    s_ready = 1'b0; s_rdata = 32'h0;
    #10;
    resetn = 1'b1;

    // m0 read of 0x100, slave acks one cycle after valid
    tick();
    m0_valid = 1'b1; m0_addr = 32'h100;
    tick();
    settle();
    chk("t1_s_valid_k1", 32'(s_valid), 32'd1);
    chk("t1_s_addr", s_addr, 32'h100);
    chk("t1_m0_ready_k1", 32'(m0_ready), 32'd0);
    tick();
    s_ready = 1'b1; s_rdata = 32'h12345678;
    settle();
    chk("t1_m0_ready_k2", 32'(m0_ready), 32'd1);
    chk("t1_m0_rdata_k2", m0_rdata, 32'h12345678);
    chk("t1_m1_ready", 32'(m1_ready), 32'd0);
    tick();
    m0_valid = 1'b0; s_ready = 1'b0;
    settle();
    chk("t1_idle_s_valid", 32'(s_valid), 32'd0);

    // Contention from reset: strict m0,m1,m0,m1 with a stale ready held in IDLE
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'hA000_0000;
    m1_valid = 1'b1; m1_addr = 32'hB000_0004;
    for (int n = 0; n < 4; n++) begin
      tick();
      s_ready = 1'b0; s_rdata = 32'h0;
      settle();
      chk($sformatf("rr%0d_s_addr", n), s_addr, (n % 2 == 0) ? 32'hA000_0000 : 32'hB000_0004);
      chk($sformatf("rr%0d_no_stale_m0", n), 32'(m0_ready), 32'd0);
      chk($sformatf("rr%0d_no_stale_m1", n), 32'(m1_ready), 32'd0);
      s_ready = 1'b1; s_rdata = 32'h1000 + 32'(n);
      settle();
      chk($sformatf("rr%0d_m0_ready", n), 32'(m0_ready), (n % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_m1_ready", n), 32'(m1_ready), (n % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      settle();
      chk($sformatf("rr%0d_idle_s_valid", n), 32'(s_valid), 32'd0);
      chk($sformatf("rr%0d_idle_m0_ready", n), 32'(m0_ready), 32'd0);
      chk($sformatf("rr%0d_idle_m1_ready", n), 32'(m1_ready), 32'd0);
    end
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
    tick();

    // m1 write passes through; m0 arrives later and waits for m1 plus IDLE
    m1_valid = 1'b1; m1_addr = 32'h200; m1_wstrb = 4'b0011; m1_wdata = 32'hAABBCCDD;
    tick();
    m0_valid = 1'b1; m0_addr = 32'h300; m0_wstrb = 4'b0000;
    settle();
    chk("wr_s_wstrb", 32'(s_wstrb), 32'h3);
    chk("wr_s_wdata", s_wdata, 32'hAABBCCDD);
    chk("wr_s_addr", s_addr, 32'h200);
    chk("wr_m0_held", 32'(m0_ready), 32'd0);
    tick();
    s_ready = 1'b1;
    settle();
    chk("wr_still_m1", s_addr, 32'h200);
    chk("wr_m1_ready", 32'(m1_ready), 32'd1);
    tick();
    m1_valid = 1'b0; m1_wstrb = 4'h0; s_ready = 1'b0;
    settle();
    chk("wr_idle", 32'(s_valid), 32'd0);
    tick();
    settle();
    chk("wr_m0_granted", s_addr, 32'h300);
    chk("wr_m0_wstrb", 32'(s_wstrb), 32'h0);
    s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
    settle();
    chk("wr_m0_ready", 32'(m0_ready), 32'd1);
    tick();
    m0_valid = 1'b0; s_ready = 1'b0;
    tick();

    // Watchdog: no ack, forced ready with ERR_DATA on the 8th granted cycle
    m0_valid = 1'b1; m0_addr = 32'h400;
    tick();
    for (int c = 1; c < 8; c++) begin
      settle();
      chk($sformatf("wd_wait%0d_ready", c), 32'(m0_ready), 32'd0);
      tick();
    end
    settle();
    chk("wd_ready", 32'(m0_ready), 32'd1);
    chk("wd_rdata", m0_rdata, 32'hDEADBEEF);
    chk("wd_err_before_edge", 32'(timeout_err), 32'd0);
    tick();
    m0_valid = 1'b0;
    settle();
    chk("wd_err_set", 32'(timeout_err), 32'd1);
    chk("wd_idle", 32'(s_valid), 32'd0);
    m1_valid = 1'b1; m1_addr = 32'h500;
    tick();
    s_ready = 1'b1; s_rdata = 32'hCAFE0001;
    settle();
    chk("wd_good_rdata", m1_rdata, 32'hCAFE0001);
    tick();
    m1_valid = 1'b0; s_ready = 1'b0;
    settle();
    chk("wd_err_sticky", 32'(timeout_err), 32'd1);

    // Requester abandons a transaction: no ready, back to IDLE
    m0_valid = 1'b1; m0_addr = 32'h600;
    tick();
    m0_valid = 1'b0;
    settle();
    chk("drop_no_ready", 32'(m0_ready), 32'd0);
    tick();
    settle();
    chk("drop_idle", 32'(s_valid), 32'd0);

    // Reset pulsed mid-GRANT1 drops everything at once; m0 then wins the tie
    m1_valid = 1'b1; m1_addr = 32'h700;
    tick();
    settle();
    chk("rg_granted", 32'(s_valid), 32'd1);
    s_ready = 1'b1;
    resetn = 1'b0;
    settle();
    chk("rg_s_valid_drop", 32'(s_valid), 32'd0);
    chk("rg_m1_ready_drop", 32'(m1_ready), 32'd0);
    chk("rg_err_cleared", 32'(timeout_err), 32'd0);
    s_ready = 1'b0;
    #8;
    resetn = 1'b1;
    m0_valid = 1'b1; m0_addr = 32'h800;
    tick();
    settle();
    chk("rg_m0_priority", s_addr, 32'h800);
    m0_valid = 1'b0; m1_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares one picorv32-native memory bus (valid/ready/instr/wstrb/wdata/addr/rdata) between two requesters, e.g. two CPU cores or a CPU and a DMA engine. It sits between the requesters and the wire-OR'ed peripheral bus feeding the on-chip RAM and I/O. It holds a grant for the whole transaction and inserts one turnaround cycle between transactions. A watchdog terminates transactions that no slave acknowledges.

## Interface
- TIMEOUT, 255: max cycles a granted transaction may wait for s_ready before forced termination (1..65535).
- ERR_DATA, 32'hDEADBEEF: rdata returned on a timed-out transaction.

- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- m0_valid, m1_valid  in  1  requester transaction request
- m0_instr, m1_instr  in  1  instruction fetch flag
- m0_wstrb, m1_wstrb  in  4  byte write strobes (0 = read)
- m0_wdata, m1_wdata  in  32  write data
- m0_addr, m1_addr  in  32  byte address
- m0_ready, m1_ready  out  1  transaction complete to requester
- m0_rdata, m1_rdata  out  32  read data to requester
- s_valid, s_instr, s_wstrb[4], s_wdata[32], s_addr[32]  out  request to shared bus
- s_ready  in  1  shared-bus acknowledge
- s_rdata  in  32  shared-bus read data
- timeout_err  out  1  sticky flag, set on any watchdog termination

## Operation
- States: IDLE, GRANT0, GRANT1. Registers: state, last_grant (1 bit), wdog counter (16 bit), timeout_err.
- IDLE: s_valid = 0, all s_* request outputs 0, m*_ready = 0. Next edge:
  - only m0_valid -> GRANT0; only m1_valid -> GRANT1;
  - both -> grant the port not equal to last_grant; neither -> stay IDLE.
  - On entering GRANTx: last_grant <= x, wdog <= 0.
- GRANTx: s_valid/s_instr/s_wstrb/s_wdata/s_addr = mx_* combinationally; mx_rdata = s_rdata, mx_ready = s_ready; other port ready = 0, rdata = 0.
  - s_ready = 1 -> IDLE at that edge.
  - s_ready = 0 and wdog == TIMEOUT-1 -> forced termination: mx_ready = 1 and mx_rdata = ERR_DATA in that cycle, timeout_err <= 1, -> IDLE. Writes are dropped.
  - Otherwise wdog increments.
  - If mx_valid drops without ready (protocol violation), -> IDLE next edge, no ready issued.
- s_ready and s_rdata are ignored in IDLE; the slave's registered ready may still be high there. The IDLE turnaround is mandatory so that a stale ready is never credited to the next transaction.
- timeout_err clears only on reset.

## Timing
- Reset (async assert): state = IDLE, last_grant = 1 (m0 wins first tie), wdog = 0, timeout_err = 0.
  - Outputs go immediately to s_valid = 0, all s_* = 0, m*_ready = 0, m*_rdata = 0.
  - A transaction in flight when reset asserts is abandoned.
  - Reset deassertion is synchronised externally.
- Request accepted at edge k (valid high in IDLE): s_valid high in cycle k+1 through the cycle of s_ready.
- With a slave answering one cycle after valid (on-chip RAM), the requester sees ready at k+2. The next grant is no earlier than the edge after the ready cycle (one IDLE cycle).
- Back-to-back contention alternates strictly m0, m1, m0, … Maximum wait for a requester is one foreign transaction plus two turnaround cycles.
- Ready and rdata to the requester are combinational from s_ready and s_rdata. There are no registers in the data path.

## Test plan
- Reset release, m0 read of 0x100, slave acks after 1 cycle with 0x12345678 -> s_valid at k+1, m0_ready and m0_rdata = 0x12345678 at k+2, m1_ready = 0 throughout.
- Both valid at the same edge after reset, each held until ready -> grants in order m0, m1, m0, m1 with exactly one IDLE cycle between each. s_addr matches the granted port.
- m1 write, wstrb = 4'b0011, data 0xAABBCCDD -> s_wstrb = 4'b0011 and s_wdata passed through unchanged. m0 held off until m1 ready and one IDLE cycle.
- Slave never acks, TIMEOUT = 8 -> m0_ready with rdata = 0xDEADBEEF exactly 8 cycles after grant. timeout_err = 1 and stays 1 across later good transactions.
- Stale s_ready held high during the IDLE cycle -> no ready issued to the newly granted port until s_ready is seen in a GRANT state.
- resetn pulsed low mid-GRANT1 -> s_valid and m1_ready drop immediately. After release, arbitration restarts with m0 priority.
